// File: rtl/mem_access_stage_p.sv
// Pipeline MEM stage: byte-addressed data RAM with sub-word loads/stores,
// configurable wait states with a stall handshake, and an access fault flag.
module mem_access_stage_p #(
   parameter int unsigned ADDR_W        = 3,
   parameter int unsigned WAIT_STATES   = 0,
   parameter int unsigned RD_W          = 5,
   parameter int unsigned WB_W          = 2,
   parameter int unsigned INIT_IDENTITY = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            validIn,
   input  logic [WB_W-1:0] writeBackControlIn,
   input  logic [1:0]      memAccessControl,
   input  logic [1:0]      accessSize,
   input  logic            loadUnsigned,
   input  logic [31:0]     resultIn,
   input  logic [31:0]     writeData,
   input  logic [RD_W-1:0] rdIn,
   output logic            stall,
   output logic            validOut,
   output logic [WB_W-1:0] writeBackControlOut,
   output logic [31:0]     readData,
   output logic [31:0]     resultOut,
   output logic [RD_W-1:0] rdOut,
   output logic            fault
);

   localparam int unsigned DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);
   localparam bit          HAS_WAIT = (WAIT_STATES != 0);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                commit;

   logic                mem_read, mem_write, mem_op;
   logic [ADDR_W-1:0]   word_idx;
   logic [1:0]          lane;
   logic                range_bad, size_bad;
   logic                access_fault, access_ok;

   logic [31:0]         ram_word [DEPTH];
   logic [31:0]         old_word, ram_wdata, load_val;
   logic [7:0]          byte_val;
   logic [15:0]         half_val;
   logic                ram_we;

   logic                valid_d, fault_d;
   logic [WB_W-1:0]     wb_d;
   logic [31:0]         rdata_d, result_d;
   logic [RD_W-1:0]     rd_d;

   assign mem_read  = memAccessControl[1];
   assign mem_write = memAccessControl[0];
   assign mem_op    = mem_read | mem_write;
   assign word_idx  = resultIn[ADDR_W+1:2];
   assign lane      = resultIn[1:0];
   assign range_bad = |resultIn[31:ADDR_W+2];

   // Alignment / size legality for the requested access
   always_comb begin
      size_bad = 1'b0;
      case (accessSize)
         2'b00:   size_bad = 1'b0;
         2'b01:   size_bad = lane[0];
         2'b10:   size_bad = (lane != 2'b00);
         default: size_bad = 1'b1;
      endcase
   end

   assign access_fault = validIn & mem_op & (range_bad | size_bad);
   assign access_ok    = validIn & mem_op & ~(range_bad | size_bad);

   // RAM words; initial contents set at time 0, untouched by rst
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ram
      logic [31:0] word_q = (INIT_IDENTITY != 0) ? 32'(gi) : 32'd0;

      // Commit a store into this word
      always_ff @(negedge clk) begin
         if (!rst && ram_we && (word_idx == ADDR_W'(gi)))
            word_q <= ram_wdata;
      end

      assign ram_word[gi] = word_q;
   end

   assign old_word = ram_word[word_idx];
   assign byte_val = old_word[{lane, 3'b000} +: 8];
   assign half_val = old_word[{lane[1], 4'b0000} +: 16];

   // Load extraction with sign/zero extension
   always_comb begin
      load_val = old_word;
      case (accessSize)
         2'b00:   load_val = loadUnsigned ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
         2'b01:   load_val = loadUnsigned ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
         default: load_val = old_word;
      endcase
   end

   // Store merge: replace only the addressed lanes
   always_comb begin
      ram_wdata = old_word;
      case (accessSize)
         2'b00:   ram_wdata[{lane, 3'b000} +: 8]    = writeData[7:0];
         2'b01:   ram_wdata[{lane[1], 4'b0000} +: 16] = writeData[15:0];
         default: ram_wdata = writeData;
      endcase
   end

   // Next-state, stall and commit decision
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access_ok && HAS_WAIT) begin
               stall   = 1'b1;
               state_d = S_WAIT;
               cnt_d   = WAIT_CNT;
            end else begin
               commit = 1'b1;
            end
         end
         S_WAIT: begin
            stall = (cnt_q != 4'd1);
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ram_we = commit & access_ok & mem_write;

   // Output bundle; bubbles and uncommitted cycles present all zeros
   always_comb begin
      valid_d  = commit & validIn;
      fault_d  = commit & access_fault;
      wb_d     = (commit && validIn && !access_fault) ? writeBackControlIn : '0;
      rdata_d  = (commit && access_ok && mem_read) ? load_val : 32'd0;
      result_d = commit ? resultIn : 32'd0;
      rd_d     = commit ? rdIn : '0;
   end

   // State register
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output registers
   always_ff @(negedge clk) begin
      if (rst) begin
         validOut            <= 1'b0;
         writeBackControlOut <= '0;
         readData            <= 32'd0;
         resultOut           <= 32'd0;
         rdOut               <= '0;
         fault               <= 1'b0;
      end else begin
         validOut            <= valid_d;
         writeBackControlOut <= wb_d;
         readData            <= rdata_d;
         resultOut           <= result_d;
         rdOut               <= rd_d;
         fault               <= fault_d;
      end
   end

endmodule

// File: tb/tb_mem_access_stage_p.sv
// Scoreboard bench for mem_access_stage_p: three instances with 0, 2 and 3 wait states.
module tb_mem_access_stage_p;

   localparam int N = 3;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] result;
      logic [4:0]  rd;
      logic [1:0]  wb;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst       [N];
   logic        valid_in  [N];
   logic [1:0]  wb_in     [N];
   logic [1:0]  mac       [N];
   logic [1:0]  size      [N];
   logic        uns       [N];
   logic [31:0] res_in    [N];
   logic [31:0] wdata     [N];
   logic [4:0]  rd_in     [N];
   logic        stall     [N];
   logic        valid_out [N];
   logic [1:0]  wb_out    [N];
   logic [31:0] rdata_out [N];
   logic [31:0] res_out   [N];
   logic [4:0]  rd_out    [N];
   logic        fault_out [N];

   exp_t q0[$], q1[$], q2[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic mon_en   = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_access_stage_p #(
         .ADDR_W(3), .WAIT_STATES((g == 0) ? 0 : g + 1), .RD_W(5), .WB_W(2), .INIT_IDENTITY(1)
      ) dut (
         .clk(clk), .rst(rst[g]), .validIn(valid_in[g]), .writeBackControlIn(wb_in[g]),
         .memAccessControl(mac[g]), .accessSize(size[g]), .loadUnsigned(uns[g]),
         .resultIn(res_in[g]), .writeData(wdata[g]), .rdIn(rd_in[g]), .stall(stall[g]),
         .validOut(valid_out[g]), .writeBackControlOut(wb_out[g]), .readData(rdata_out[g]),
         .resultOut(res_out[g]), .rdOut(rd_out[g]), .fault(fault_out[g])
      );
   end

   function automatic void push(input int i, input exp_t e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t pop(input int i);
      case (i)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic clear(input int i);
      valid_in[i] = 1'b0; wb_in[i] = 2'b00; mac[i] = 2'b00; size[i] = 2'b00;
      uns[i] = 1'b0; res_in[i] = 32'd0; wdata[i] = 32'd0; rd_in[i] = 5'd0;
   endtask

   // Issue one bundle, hold it while stalled, release after the accepting edge
   task automatic send(input int i, input logic v, input logic [1:0] ctl, input logic [1:0] sz,
                       input logic u, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] exp_rdata,
                       input logic exp_fault, input int exp_stall);
      exp_t e;
      int   cycles;
      @(posedge clk);
      valid_in[i] = v; mac[i] = ctl; size[i] = sz; uns[i] = u;
      res_in[i] = addr; wdata[i] = wd; rd_in[i] = rd; wb_in[i] = {rd[0], 1'b1};
      if (v) begin
         e.rdata  = exp_rdata;
         e.result = addr;
         e.rd     = rd;
         e.wb     = exp_fault ? 2'b00 : {rd[0], 1'b1};
         e.fault  = exp_fault;
         push(i, e);
      end
      cycles = 0;
      #1;
      while (stall[i] && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
      n_checks++;
      if (cycles != exp_stall) begin
         n_fail++;
         $display("FAIL stall_cycles inst%0d addr=%h: got %0d, expected %0d", i, addr, cycles, exp_stall);
      end
      @(negedge clk); #1;
      clear(i);
   endtask

   // Monitor: compare every presented output bundle against the queue head
   initial begin
      exp_t a, e;
      forever begin
         @(posedge clk);
         if (mon_en) begin
            for (int i = 0; i < N; i++) begin
               if (valid_out[i]) begin
                  a.rdata = rdata_out[i]; a.result = res_out[i]; a.rd = rd_out[i];
                  a.wb = wb_out[i]; a.fault = fault_out[i];
                  n_checks++;
                  if (qsize(i) == 0) begin
                     n_fail++;
                     $display("FAIL unexpected_output inst%0d: got result=%h rdata=%h, expected no output",
                              i, a.result, a.rdata);
                  end else begin
                     e = pop(i);
                     if (a !== e) begin
                        n_fail++;
                        $display("FAIL txn inst%0d: got rdata=%h result=%h rd=%h wb=%h fault=%b, expected rdata=%h result=%h rd=%h wb=%h fault=%b",
                                 i, a.rdata, a.result, a.rd, a.wb, a.fault,
                                 e.rdata, e.result, e.rd, e.wb, e.fault);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1;
         clear(i);
      end
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if ({valid_out[i], wb_out[i], rdata_out[i], res_out[i], rd_out[i], fault_out[i], stall[i]} != '0) begin
            n_fail++;
            $display("FAIL reset_state inst%0d: got valid=%b wb=%h rdata=%h result=%h rd=%h fault=%b stall=%b, expected all 0",
                     i, valid_out[i], wb_out[i], rdata_out[i], res_out[i], rd_out[i], fault_out[i], stall[i]);
         end
      end
      mon_en = 1'b1;

      // No wait states: loads, sub-word stores, extension
      send(0, 1, 2'b10, 2'b10, 0, 32'h14, 32'h0,        5'd1,  32'h0000_0005, 0, 0);
      send(0, 1, 2'b01, 2'b00, 0, 32'h09, 32'h0000_00AB, 5'd2,  32'h0,         0, 0);
      send(0, 1, 2'b10, 2'b00, 0, 32'h09, 32'h0,        5'd3,  32'hFFFF_FFAB, 0, 0);
      send(0, 1, 2'b10, 2'b00, 1, 32'h09, 32'h0,        5'd4,  32'h0000_00AB, 0, 0);
      send(0, 1, 2'b10, 2'b10, 0, 32'h08, 32'h0,        5'd5,  32'h0000_AB02, 0, 0);
      send(0, 1, 2'b01, 2'b01, 0, 32'h0E, 32'hFFFF_8001, 5'd6,  32'h0,         0, 0);
      send(0, 1, 2'b10, 2'b01, 0, 32'h0E, 32'h0,        5'd7,  32'hFFFF_8001, 0, 0);
      send(0, 1, 2'b10, 2'b01, 1, 32'h0C, 32'h0,        5'd8,  32'h0000_0003, 0, 0);
      send(0, 1, 2'b10, 2'b00, 0, 32'h0F, 32'h0,        5'd9,  32'hFFFF_FF80, 0, 0);
      // Faults: misaligned half/word, illegal size, out of range store
      send(0, 1, 2'b10, 2'b01, 0, 32'h03, 32'h0,        5'd10, 32'h0,         1, 0);
      send(0, 1, 2'b10, 2'b10, 0, 32'h06, 32'h0,        5'd11, 32'h0,         1, 0);
      send(0, 1, 2'b10, 2'b11, 0, 32'h00, 32'h0,        5'd12, 32'h0,         1, 0);
      send(0, 1, 2'b01, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 5'd13, 32'h0,         1, 0);
      send(0, 1, 2'b10, 2'b10, 0, 32'h00, 32'h0,        5'd14, 32'h0,         0, 0);
      // Non-memory op with an out of range result: no fault, plain pass-through
      send(0, 1, 2'b00, 2'b11, 0, 32'h40, 32'h0,        5'd15, 32'h0,         0, 0);
      // Read+write returns old data; invalid store must not write
      send(0, 1, 2'b11, 2'b10, 0, 32'h18, 32'h0000_0055, 5'd16, 32'h0000_0006, 0, 0);
      send(0, 1, 2'b10, 2'b10, 0, 32'h18, 32'h0,        5'd17, 32'h0000_0055, 0, 0);
      send(0, 0, 2'b01, 2'b10, 0, 32'h1C, 32'h1111_1111, 5'd18, 32'h0,         0, 0);
      send(0, 1, 2'b10, 2'b10, 0, 32'h1C, 32'h0,        5'd19, 32'h0000_0007, 0, 0);

      // Two wait states
      send(1, 1, 2'b10, 2'b10, 0, 32'h0C, 32'h0,        5'd20, 32'h0000_0003, 0, 2);
      send(1, 1, 2'b01, 2'b00, 0, 32'h0D, 32'h0000_00CD, 5'd21, 32'h0,         0, 2);
      send(1, 1, 2'b10, 2'b10, 0, 32'h0C, 32'h0,        5'd22, 32'h0000_CD03, 0, 2);
      send(1, 1, 2'b10, 2'b10, 0, 32'h0D, 32'h0,        5'd23, 32'h0,         1, 0);
      send(1, 1, 2'b00, 2'b10, 0, 32'h0C, 32'h0,        5'd24, 32'h0,         0, 0);

      // Three wait states: reset during the wait aborts the store
      @(posedge clk);
      valid_in[2] = 1'b1; mac[2] = 2'b01; size[2] = 2'b10; res_in[2] = 32'h10;
      wdata[2] = 32'h0000_1234; rd_in[2] = 5'd25; wb_in[2] = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      rst[2] = 1'b1;
      clear(2);
      @(negedge clk);
      #1;
      rst[2] = 1'b0;
      @(posedge clk);
      n_checks++;
      if ({valid_out[2], wb_out[2], rdata_out[2], res_out[2], rd_out[2], fault_out[2]} != '0) begin
         n_fail++;
         $display("FAIL abort_outputs inst2: got valid=%b rdata=%h result=%h fault=%b, expected all 0",
                  valid_out[2], rdata_out[2], res_out[2], fault_out[2]);
      end
      n_checks++;
      if (stall[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_stall inst2: got %b, expected 0", stall[2]);
      end
      send(2, 1, 2'b10, 2'b10, 0, 32'h10, 32'h0,        5'd26, 32'h0000_0004, 0, 3);
      send(2, 1, 2'b01, 2'b10, 0, 32'h10, 32'h0000_1234, 5'd27, 32'h0,         0, 3);
      send(2, 1, 2'b10, 2'b10, 0, 32'h10, 32'h0,        5'd28, 32'h0000_1234, 0, 3);

      repeat (5) @(posedge clk);
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (qsize(i) != 0) begin
            n_fail++;
            $display("FAIL missing_output inst%0d: got %0d pending, expected 0", i, qsize(i));
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
